banco_registradores_param: RTL and testbench
============================================

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
- REQ-001: Parameter LARGURA, default 32, is the register data width in bits and SHALL be a multiple of 8.
- REQ-002: Parameter NUM_REGS, default 32, is the register count and SHALL be a power of two, at least 2.
- REQ-003: Derived parameter ADDR_W SHALL equal clog2(NUM_REGS), and derived parameter NB SHALL equal LARGURA/8.
- REQ-004: The block SHALL have one clock and an asynchronous, active-low reset.
- REQ-005: Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-006: Port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007: Ports endereco_leitura_1 and endereco_leitura_2, input, ADDR_W bits each: the two read addresses.
- REQ-008: Ports Rs and Rt, output, LARGURA bits each: read data for endereco_leitura_1 and endereco_leitura_2.
- REQ-009: Port endereco_escrita, input, ADDR_W bits: write address.
- REQ-010: Port escrever_dados, input, LARGURA bits: write data.
- REQ-011: Port Reg_Write, input, 1 bit: write enable.
- REQ-012: Port byte_enable, input, NB bits: per-byte write mask; bit i covers data bits [8i+7:8i].
- REQ-013: Port reservar, input, 1 bit: marks register endereco_reserva as pending.
- REQ-014: Port endereco_reserva, input, ADDR_W bits: address of the register to reserve.
- REQ-015: Ports pendente_1 and pendente_2, output, 1 bit each: pending status of endereco_leitura_1 and endereco_leitura_2.
- REQ-016: Port num_pendentes, output, ADDR_W+1 bits, registered: count of registers currently pending.

Function
- REQ-017: A write SHALL occur on a rising clock edge when Reg_Write=1 and endereco_escrita!=0; only bytes with byte_enable[i]=1 are updated and all other bytes are retained.
- REQ-018: Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never become pending.
- REQ-019: Reads SHALL be combinational; with no write to the same address in the current cycle, Rs and Rt SHALL show the stored value.
- REQ-020: Write bypass: when Reg_Write=1, endereco_escrita equals a read address, and that address is nonzero, the read output SHALL show the stored value with the enabled bytes replaced by escrever_dados in the same cycle.
- REQ-021: Both read ports SHALL be independent; both may bypass the same write at once.
- REQ-022: Each pending bit SHALL be set at the clock edge when reservar=1 and endereco_reserva!=0.
- REQ-023: Each pending bit SHALL be cleared at the clock edge when Reg_Write=1 to that address, whatever the byte_enable value, including all-zero.
- REQ-024: If reservar and Reg_Write target the same address in the same cycle, set SHALL win: the bit is pending after the edge.
- REQ-025: Reserving an address that is already pending SHALL leave it pending and SHALL NOT change num_pendentes.
- REQ-026: pendente_x SHALL equal pend[addr] AND NOT (Reg_Write=1 with endereco_escrita==addr); a same-cycle write therefore hides pending.
- REQ-027: num_pendentes SHALL equal, one cycle later, the population count of the pending bits after each edge: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both happen in one cycle.
- REQ-028: num_pendentes SHALL never exceed NUM_REGS-1 and SHALL not wrap.
- REQ-029: An address out of range cannot occur, because NUM_REGS is a power of two.

Reset
- REQ-030: When reset_n=0, all registers, all pending bits and num_pendentes SHALL clear to 0 immediately, independent of clock.
- REQ-031: While reset_n=0, Rs, Rt, pendente_1 and pendente_2 SHALL read 0, except for bypass data on the read outputs, which SHALL be suppressed.
- REQ-032: Writes and reservations presented during reset SHALL be discarded.
- REQ-033: Normal operation SHALL resume at the first rising edge after reset_n rises.
- REQ-034: Asserting reset in the middle of a sequence SHALL lose all state, with no partial write.

Verification
- REQ-035: Write 0xDEADBEEF to r5 with byte_enable=1111, then write 0x000000AA with byte_enable=0001 -> Rs(r5)=0xDEADBEAA.
- REQ-036: Write 0x12345678 to r0, with r0 reserved in the same cycle -> Rs(r0)=0, pendente_1=0, num_pendentes unchanged.
- REQ-037: r7 holds 0x0; in the same cycle present a write of 0xCAFEF00D to r7 with byte_enable=1100 and read it on both ports -> Rs=Rt=0xCAFE0000 in that cycle.
- REQ-038: Reserve r3 -> next cycle pendente_1(r3)=1 and num_pendentes=1; then write r3 -> pendente_1=0 in the write cycle and num_pendentes=0 after the edge.
- REQ-039: Reserve r4 and write r4 in the same cycle -> pendente(r4)=1 and num_pendentes=1.
- REQ-040: Load r1 and r2 and reserve r9, then assert reset_n=0 between clock edges -> all reads 0 and num_pendentes=0 at once; a write during reset has no effect.

Source files
------------

// File: rtl/banco_registradores_param.sv
// banco_registradores_param
//   Register file with byte-masked writes, two combinational read ports with
//   write bypass, and a per-register "pending" scoreboard with a registered
//   population count.
//
// Ports
//   clock              : single clock, rising-edge active
//   reset_n            : asynchronous active-low reset
//   endereco_leitura_1 : read address for Rs / pendente_1
//   endereco_leitura_2 : read address for Rt / pendente_2
//   Rs, Rt             : combinational read data (write-bypassed)
//   endereco_escrita   : write address
//   escrever_dados     : write data
//   Reg_Write          : write enable (also clears the pending bit)
//   byte_enable        : per-byte write mask, bit i covers bits [8i+7:8i]
//   reservar           : mark endereco_reserva as pending
//   endereco_reserva   : address to reserve
//   pendente_1/2       : pending status of the two read addresses
//   num_pendentes      : registered count of pending registers
//
// Register 0 is hardwired to zero and can never become pending.
module banco_registradores_param #(
  parameter int LARGURA  = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int NB      = LARGURA / 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   endereco_leitura_1,
  input  logic [ADDR_W-1:0]   endereco_leitura_2,
  output logic [LARGURA-1:0]  Rs,
  output logic [LARGURA-1:0]  Rt,
  input  logic [ADDR_W-1:0]   endereco_escrita,
  input  logic [LARGURA-1:0]  escrever_dados,
  input  logic                Reg_Write,
  input  logic [NB-1:0]       byte_enable,
  input  logic                reservar,
  input  logic [ADDR_W-1:0]   endereco_reserva,
  output logic                pendente_1,
  output logic                pendente_2,
  output logic [ADDR_W:0]     num_pendentes
);

  logic [LARGURA-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [LARGURA-1:0]  wr_merged;
  logic                wr_en;

  assign wr_en = Reg_Write && (endereco_escrita != '0);

  // Stored value of the write target with the enabled bytes replaced; used
  // both for the register update and for the read bypass.
  always_comb begin
    wr_merged = regs_q[endereco_escrita];
    for (int b = 0; b < NB; b++) begin
      if (byte_enable[b]) wr_merged[8*b +: 8] = escrever_dados[8*b +: 8];
    end
  end

  // Clear on write first, then set on reserve, so a same-cycle reserve wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[endereco_escrita] = 1'b0;
    if (reservar && (endereco_reserva != '0)) pend_d[endereco_reserva] = 1'b1;
    num_d = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      num_d = num_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
      num_q  <= '0;
    end else begin
      if (wr_en) regs_q[endereco_escrita] <= wr_merged;
      pend_q <= pend_d;
      num_q  <= num_d;
    end
  end

  // Read port 1. Outputs are forced to zero during reset so that bypass data
  // cannot leak out while the array is being cleared.
  always_comb begin
    Rs         = '0;
    pendente_1 = 1'b0;
    if (reset_n && (endereco_leitura_1 != '0)) begin
      if (wr_en && (endereco_escrita == endereco_leitura_1)) begin
        Rs = wr_merged;
      end else begin
        Rs         = regs_q[endereco_leitura_1];
        pendente_1 = pend_q[endereco_leitura_1];
      end
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    Rt         = '0;
    pendente_2 = 1'b0;
    if (reset_n && (endereco_leitura_2 != '0)) begin
      if (wr_en && (endereco_escrita == endereco_leitura_2)) begin
        Rt = wr_merged;
      end else begin
        Rt         = regs_q[endereco_leitura_2];
        pendente_2 = pend_q[endereco_leitura_2];
      end
    end
  end

  assign num_pendentes = num_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
module tb_banco_registradores_param;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  endereco_leitura_1, endereco_leitura_2, endereco_escrita, endereco_reserva;
  logic [31:0] Rs, Rt, escrever_dados;
  logic        Reg_Write, reservar, pendente_1, pendente_2;
  logic [3:0]  byte_enable;
  logic [5:0]  num_pendentes;

  int checks = 0;
  int errors = 0;

  banco_registradores_param #(.LARGURA(32), .NUM_REGS(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .endereco_leitura_1(endereco_leitura_1), .endereco_leitura_2(endereco_leitura_2),
    .Rs(Rs), .Rt(Rt),
    .endereco_escrita(endereco_escrita), .escrever_dados(escrever_dados),
    .Reg_Write(Reg_Write), .byte_enable(byte_enable),
    .reservar(reservar), .endereco_reserva(endereco_reserva),
    .pendente_1(pendente_1), .pendente_2(pendente_2),
    .num_pendentes(num_pendentes)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed well away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    Reg_Write = 1'b0;
    reservar  = 1'b0;
    byte_enable = 4'b0000;
    escrever_dados = '0;
    endereco_escrita = '0;
    endereco_reserva = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    endereco_leitura_1 = 5'd0;
    endereco_leitura_2 = 5'd0;
    #2;
    chk("reset_rs", Rs, 32'h0);
    chk("reset_num", {26'd0, num_pendentes}, 32'd0);
    chk("reset_pend1", {31'd0, pendente_1}, 32'd0);
    #20;
    reset_n = 1'b1;
    tick();

    // Full write then low-byte overwrite of r5.
    Reg_Write = 1'b1; endereco_escrita = 5'd5; escrever_dados = 32'hDEADBEEF; byte_enable = 4'b1111;
    tick();
    escrever_dados = 32'h000000AA; byte_enable = 4'b0001; endereco_leitura_1 = 5'd5;
    #1;
    chk("r5_bypass_partial", Rs, 32'hDEADBEAA);
    tick();
    idle();
    #1;
    chk("r5_stored", Rs, 32'hDEADBEAA);

    // r0 ignores writes and reservations.
    Reg_Write = 1'b1; endereco_escrita = 5'd0; escrever_dados = 32'h12345678; byte_enable = 4'b1111;
    reservar = 1'b1; endereco_reserva = 5'd0; endereco_leitura_1 = 5'd0;
    #1;
    chk("r0_bypass", Rs, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_read", Rs, 32'h0);
    chk("r0_pend", {31'd0, pendente_1}, 32'd0);
    chk("r0_num", {26'd0, num_pendentes}, 32'd0);

    // Upper-half write to r7 bypassed on both ports.
    Reg_Write = 1'b1; endereco_escrita = 5'd7; escrever_dados = 32'hCAFEF00D; byte_enable = 4'b1100;
    endereco_leitura_1 = 5'd7; endereco_leitura_2 = 5'd7;
    #1;
    chk("r7_bypass_rs", Rs, 32'hCAFE0000);
    chk("r7_bypass_rt", Rt, 32'hCAFE0000);
    tick();
    idle();
    endereco_leitura_2 = 5'd5;
    #1;
    chk("r7_stored", Rs, 32'hCAFE0000);
    chk("rt_independent", Rt, 32'hDEADBEAA);

    // Reserve r3, then clear it with an all-zero byte_enable write.
    reservar = 1'b1; endereco_reserva = 5'd3; endereco_leitura_1 = 5'd3;
    #1;
    chk("r3_pend_before_edge", {31'd0, pendente_1}, 32'd0);
    tick();
    idle();
    #1;
    chk("r3_pend_set", {31'd0, pendente_1}, 32'd1);
    chk("r3_num_1", {26'd0, num_pendentes}, 32'd1);
    Reg_Write = 1'b1; endereco_escrita = 5'd3; escrever_dados = 32'hFFFFFFFF; byte_enable = 4'b0000;
    #1;
    chk("r3_pend_hidden", {31'd0, pendente_1}, 32'd0);
    chk("r3_num_still_1", {26'd0, num_pendentes}, 32'd1);
    tick();
    idle();
    #1;
    chk("r3_pend_clear", {31'd0, pendente_1}, 32'd0);
    chk("r3_num_0", {26'd0, num_pendentes}, 32'd0);
    chk("r3_data_kept", Rs, 32'h0);

    // Reserve and write r4 together: set wins.
    reservar = 1'b1; endereco_reserva = 5'd4;
    Reg_Write = 1'b1; endereco_escrita = 5'd4; escrever_dados = 32'h11223344; byte_enable = 4'b1111;
    endereco_leitura_1 = 5'd4;
    tick();
    idle();
    #1;
    chk("r4_pend", {31'd0, pendente_1}, 32'd1);
    chk("r4_num", {26'd0, num_pendentes}, 32'd1);
    chk("r4_data", Rs, 32'h11223344);

    // Re-reserving r4 keeps the count.
    reservar = 1'b1; endereco_reserva = 5'd4;
    tick();
    idle();
    #1;
    chk("r4_rereserve_num", {26'd0, num_pendentes}, 32'd1);

    // Reserve r6 while clearing r4: net zero.
    reservar = 1'b1; endereco_reserva = 5'd6;
    Reg_Write = 1'b1; endereco_escrita = 5'd4; escrever_dados = 32'h0; byte_enable = 4'b0000;
    tick();
    idle();
    endereco_leitura_2 = 5'd6;
    #1;
    chk("net0_num", {26'd0, num_pendentes}, 32'd1);
    chk("net0_r4_pend", {31'd0, pendente_1}, 32'd0);
    chk("net0_r6_pend", {31'd0, pendente_2}, 32'd1);

    // Load r1, r2, reserve r9, then reset mid-cycle.
    Reg_Write = 1'b1; endereco_escrita = 5'd1; escrever_dados = 32'h01010101; byte_enable = 4'b1111;
    tick();
    endereco_escrita = 5'd2; escrever_dados = 32'h02020202;
    reservar = 1'b1; endereco_reserva = 5'd9;
    tick();
    idle();
    endereco_leitura_1 = 5'd1; endereco_leitura_2 = 5'd2;
    #1;
    chk("pre_reset_r1", Rs, 32'h01010101);
    chk("pre_reset_r2", Rt, 32'h02020202);
    chk("pre_reset_num", {26'd0, num_pendentes}, 32'd2);
    Reg_Write = 1'b1; endereco_escrita = 5'd1; escrever_dados = 32'h55555555; byte_enable = 4'b1111;
    reservar = 1'b1; endereco_reserva = 5'd1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("in_reset_rs", Rs, 32'h0);
    chk("in_reset_rt", Rt, 32'h0);
    chk("in_reset_num", {26'd0, num_pendentes}, 32'd0);
    tick();
    #1;
    chk("in_reset_after_edge_rs", Rs, 32'h0);
    idle();
    #1;
    reset_n = 1'b1;
    endereco_leitura_2 = 5'd9;
    #1;
    chk("post_reset_r1", Rs, 32'h0);
    chk("post_reset_r9_pend", {31'd0, pendente_2}, 32'd0);
    tick();
    #1;
    chk("post_reset_num", {26'd0, num_pendentes}, 32'd0);
    chk("post_reset_r1_pend", {31'd0, pendente_1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
